// File: rtl/stream_demux.sv
// One-to-two stream demultiplexer with a single-entry
// register per channel; STREAM_DEMUX_COUNT_EN adds counters.
module stream_demux #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
`endif
);

  logic a_free;
  logic b_free;
  logic acc_a;
  logic acc_b;
  logic dlv_a;
  logic dlv_b;

  // A slot can take a word if empty or draining this cycle.
  always_comb begin
    a_free   = !a_valid || a_ready;
    b_free   = !b_valid || b_ready;
    in_ready = sel ? b_free : a_free;
    acc_a    = in_valid && in_ready && !sel;
    acc_b    = in_valid && in_ready && sel;
    dlv_a    = a_valid && a_ready;
    dlv_b    = b_valid && b_ready;
  end

  // Channel a slot: load wins over drain for bubble-free flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else if (acc_a) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
    end else if (dlv_a) begin
      a_valid <= 1'b0;
    end
  end

  // Channel b slot: same policy as channel a.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else if (acc_b) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
    end else if (dlv_b) begin
      b_valid <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_COUNT_EN
  // Saturating delivery counters, one per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count <= 8'd0;
      b_count <= 8'd0;
    end else begin
      if (dlv_a && a_count != 8'hff)
        a_count <= a_count + 8'd1;
      if (dlv_b && b_count != 8'hff)
        b_count <= b_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus
// randomized traffic against a queue-based model.
module tb_stream_demux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         sel = 1'b0;
  logic         a_valid;
  logic         a_ready = 1'b0;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready = 1'b0;
  logic [W-1:0] b_data;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [7:0]   a_count;
  logic [7:0]   b_count;
`endif

  int vecs = 0;
  int errs = 0;

  // Model: each channel is a FIFO of depth one.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] la = '0;
  logic [W-1:0] lb = '0;
  int ca = 0;
  int cb = 0;

  stream_demux #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .sel(sel),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_data(b_data)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .a_count(a_count),
    .b_count(b_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_rdy();
    if (sel)
      return qb.size() == 0 || b_ready;
    return qa.size() == 0 || a_ready;
  endfunction

  function automatic logic [W-1:0] m_ad();
    return qa.size() != 0 ? qa[0] : la;
  endfunction

  function automatic logic [W-1:0] m_bd();
    return qb.size() != 0 ? qb[0] : lb;
  endfunction

  function automatic logic [7:0] sat(int c);
    return c > 255 ? 8'hff : 8'(c);
  endfunction

  // Advance the model and the DUT by one clock edge.
  task automatic tick();
    bit r;
    if (rst) begin
      qa.delete();
      qb.delete();
      la = '0;
      lb = '0;
      ca = 0;
      cb = 0;
    end else begin
      r = m_rdy();
      if (qa.size() != 0 && a_ready) begin
        la = qa.pop_front();
        ca++;
      end
      if (qb.size() != 0 && b_ready) begin
        lb = qb.pop_front();
        cb++;
      end
      if (in_valid && r) begin
        if (sel) qb.push_back(in_data);
        else qa.push_back(in_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vecs++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid got a=%b b=%b exp 0 0",
               a_valid, b_valid);
    end
    vecs++;
    if (a_data !== '0 || b_data !== '0) begin
      errs++;
      $display("FAIL reset_data got a=%h b=%h exp 0 0",
               a_data, b_data);
    end
    sel = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_rdy0 got %b exp 1", in_ready);
    end
    sel = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_rdy1 got %b exp 1", in_ready);
    end
`ifdef STREAM_DEMUX_COUNT_EN
    vecs++;
    if (a_count !== 8'd0 || b_count !== 8'd0) begin
      errs++;
      $display("FAIL reset_cnt got %0d %0d exp 0 0",
               a_count, b_count);
    end
`endif
  endtask

  task automatic test_single();
    a_ready = 1'b0;
    b_ready = 1'b0;
    sel = 1'b0;
    in_data = 8'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    vecs++;
    if (a_valid !== 1'b1 || a_data !== 8'd1) begin
      errs++;
      $display("FAIL single_a got v=%b d=%h exp 1 01",
               a_valid, a_data);
    end
    vecs++;
    if (b_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_b got %b exp 0", b_valid);
    end
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL single_rdy got %b exp 0", in_ready);
    end
  endtask

  task automatic test_cross();
    sel = 1'b1;
    in_data = 8'd1;
    in_valid = 1'b1;
    b_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL cross_rdy got %b exp 1", in_ready);
    end
    b_ready = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL cross_rdy_nb got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    vecs++;
    if (b_valid !== 1'b1 || b_data !== 8'd1) begin
      errs++;
      $display("FAIL cross_b got v=%b d=%h exp 1 01",
               b_valid, b_data);
    end
    vecs++;
    if (a_valid !== 1'b1 || a_data !== 8'd1) begin
      errs++;
      $display("FAIL cross_a got v=%b d=%h exp 1 01",
               a_valid, a_data);
    end
  endtask

  task automatic test_stall();
    a_ready = 1'b0;
    sel = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hc3;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      vecs++;
      if (a_valid !== 1'b1 || a_data !== 8'd1
          || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL stall_%0d got v=%b d=%h r=%b exp 1 01 0",
                 i, a_valid, a_data, in_ready);
      end
    end
    in_valid = 1'b0;
    a_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL stall_release got %b exp 1", in_ready);
    end
    tick();
    a_ready = 1'b0;
    #1;
    vecs++;
    if (a_valid !== 1'b0 || a_data !== 8'd1) begin
      errs++;
      $display("FAIL stall_drain got v=%b d=%h exp 0 01",
               a_valid, a_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] p;
    a_ready = 1'b1;
    sel = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = W'(i % 2);
      in_data = p;
      #1;
      vecs++;
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL b2b_rdy_%0d got %b exp 1", i, in_ready);
      end
      tick();
      #1;
      vecs++;
      if (a_valid !== 1'b1 || a_data !== p) begin
        errs++;
        $display("FAIL b2b_%0d got v=%b d=%h exp 1 %h",
                 i, a_valid, a_data, p);
      end
    end
    in_valid = 1'b0;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    a_ready = 1'b0;
    b_ready = 1'b0;
    in_valid = 1'b1;
    sel = 1'b0;
    in_data = 8'h3c;
    tick();
    sel = 1'b1;
    in_data = 8'ha5;
    tick();
    #1;
    vecs++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
      errs++;
      $display("FAIL full_fill got a=%b b=%b exp 1 1",
               a_valid, b_valid);
    end
    a_ready = 1'b1;
    b_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    #1;
    vecs++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0
        || a_data !== '0 || b_data !== '0) begin
      errs++;
      $display("FAIL full_rst got %b %b %h %h exp 0 0 00 00",
               a_valid, b_valid, a_data, b_data);
    end
`ifdef STREAM_DEMUX_COUNT_EN
    vecs++;
    if (a_count !== 8'd0 || b_count !== 8'd0) begin
      errs++;
      $display("FAIL full_rst_cnt got %0d %0d exp 0 0",
               a_count, b_count);
    end
`endif
    sel = 1'b0;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL full_rdy0 got %b exp 1", in_ready);
    end
    sel = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL full_rdy1 got %b exp 1", in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      sel = 1'($urandom);
      in_data = W'($urandom);
      a_ready = $urandom_range(0, 2) != 0;
      b_ready = $urandom_range(0, 2) != 0;
      #1;
      vecs++;
      if (in_ready !== m_rdy()) begin
        errs++;
        $display("FAIL rnd_rdy_%0d got %b exp %b",
                 i, in_ready, m_rdy());
      end
      vecs++;
      if (a_valid !== (qa.size() != 0)
          || a_data !== m_ad()) begin
        errs++;
        $display("FAIL rnd_a_%0d got %b %h exp %b %h",
                 i, a_valid, a_data, qa.size() != 0, m_ad());
      end
      vecs++;
      if (b_valid !== (qb.size() != 0)
          || b_data !== m_bd()) begin
        errs++;
        $display("FAIL rnd_b_%0d got %b %h exp %b %h",
                 i, b_valid, b_data, qb.size() != 0, m_bd());
      end
`ifdef STREAM_DEMUX_COUNT_EN
      vecs++;
      if (a_count !== sat(ca) || b_count !== sat(cb)) begin
        errs++;
        $display("FAIL rnd_cnt_%0d got %0d %0d exp %0d %0d",
                 i, a_count, b_count, sat(ca), sat(cb));
      end
`endif
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

`ifdef STREAM_DEMUX_COUNT_EN
  task automatic test_count();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_ready = 1'b1;
    a_ready = 1'b1;
    sel = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = W'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    #1;
    vecs++;
    if (cb != 300) begin
      errs++;
      $display("FAIL cnt_model got %0d exp 300", cb);
    end
    vecs++;
    if (b_count !== 8'd255 || a_count !== 8'd0) begin
      errs++;
      $display("FAIL cnt_sat got b=%0d a=%0d exp 255 0",
               b_count, a_count);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_cross();
    test_stall();
    test_back_to_back();
    test_reset_full();
    test_random();
`ifdef STREAM_DEMUX_COUNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
